// File: rtl/wait_sequencer.sv
// Timer start/done initiator: runs the wait timer for N done periods and acks once.
// Optional watchdog on the gap between timer_done pulses: define WAIT_SEQ_WATCHDOG_EN.
module wait_sequencer #(
  parameter int TICK_W   = 8,
  parameter int WD_LIMIT = 10_500_000,
  parameter int WD_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [TICK_W-1:0] ticks,
  input  logic              abort,
  input  logic              timer_done,
  output logic              timer_start,
  output logic              busy,
  output logic              ack,
  output logic [TICK_W-1:0] ticks_left,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] ticks_nxt;
  logic              wd_expired;

`ifdef WAIT_SEQ_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside RUN, so every entry into RUN starts a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != RUN || timer_done) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(WD_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (state_nxt == ERR);
    end
  end
`else
  logic [WD_W-1:0] unused_wd_limit;

  assign unused_wd_limit = WD_W'(WD_LIMIT);
  assign wd_expired      = 1'b0;
  assign err             = 1'b0;
`endif

  // A done pulse in the same cycle as watchdog expiry counts as on time.
  always_comb begin
    state_nxt = state;
    ticks_nxt = ticks_left;
    case (state)
      IDLE: begin
        if (req) begin
          if (ticks != '0) begin
            state_nxt = RUN;
            ticks_nxt = ticks;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          ticks_nxt = '0;
        end else if (timer_done) begin
          if (ticks_left != '0) begin
            ticks_nxt = ticks_left - TICK_W'(1);
          end
          if (ticks_left == TICK_W'(1)) begin
            state_nxt = DONE;
          end
        end else if (wd_expired) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      ERR: begin
        if (abort) begin
          state_nxt = IDLE;
          ticks_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ticks_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ticks_left  <= '0;
      timer_start <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
    end else begin
      state       <= state_nxt;
      ticks_left  <= ticks_nxt;
      timer_start <= (state_nxt == RUN);
      busy        <= (state_nxt == RUN);
      ack         <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_wait_sequencer.sv
// Self-checking bench for wait_sequencer: directed scenarios with a 5-cycle timer stub,
// then randomized traffic, all compared every cycle against a transaction-level model.
module tb_wait_sequencer;

  localparam int TW  = 8;
  localparam int WDL = 20;
`ifdef WAIT_SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [TW-1:0] ticks;
  logic          abort;
  logic          timer_done;
  logic          timer_start;
  logic          busy;
  logic          ack;
  logic [TW-1:0] ticks_left;
  logic          err;

  wait_sequencer #(
    .TICK_W  (TW),
    .WD_LIMIT(WDL),
    .WD_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ticks      (ticks),
    .abort      (abort),
    .timer_done (timer_done),
    .timer_start(timer_start),
    .busy       (busy),
    .ack        (ack),
    .ticks_left (ticks_left),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model: is a wait outstanding, how many periods remain, ack due, error held.
  bit m_active = 1'b0;
  bit m_ack    = 1'b0;
  bit m_err    = 1'b0;
  int m_left   = 0;
  int m_wd     = 0;

  // Timer stub: done every 5th cycle that start is high; keeps its phase while start is low.
  bit stub_en = 1'b1;
  bit stall   = 1'b0;
  int phase   = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit next_ack;
    next_ack = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_left   = 0;
      m_err    = 1'b0;
      m_wd     = 0;
    end else if (m_err) begin
      if (abort) begin
        m_err  = 1'b0;
        m_left = 0;
      end
    end else if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
        m_left   = 0;
      end else if (timer_done) begin
        m_left = m_left - 1;
        m_wd   = 0;
        if (m_left == 0) begin
          m_active = 1'b0;
          next_ack = 1'b1;
        end
      end else if (WD_ON && m_wd == WDL) begin
        m_active = 1'b0;
        m_err    = 1'b1;
      end else begin
        m_wd = m_wd + 1;
      end
    end else if (!m_ack && req) begin
      if (ticks == 0) begin
        next_ack = 1'b1;
      end else begin
        m_active = 1'b1;
        m_left   = int'(ticks);
        m_wd     = 0;
      end
    end
    m_ack = next_ack;
  endtask

  task automatic step();
    bit st;
    st = timer_start;
    if (stub_en) timer_done = st && (phase == 4) && !stall;
    @(posedge clk);
    model_step();
    if (reset) phase = 0;
    else if (st && !stall) phase = (phase == 4) ? 0 : phase + 1;
    #1;
    chk("timer_start", timer_start, m_active);
    chk("busy", busy, m_active);
    chk("ack", ack, m_ack);
    chk("ticks_left", ticks_left, m_left);
    chk("err", err, m_err);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int ack_at;
    int err_at;
    int dn;
    int n_ack;
    bit will_done;

    reset = 1'b1; req = 1'b0; ticks = '0; abort = 1'b0; timer_done = 1'b0;

    // T1: reset held two cycles
    step();
    step();
    chk("t1_start", timer_start, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ack", ack, 0);
    chk("t1_left", ticks_left, 0);
    chk("t1_err", err, 0);
    reset = 1'b0;

    // T2: three periods, dones land 5, 10 and 15 cycles after the request edge
    req = 1'b1; ticks = 8'd3;
    step();
    req = 1'b0;
    chk("t2_start", timer_start, 1);
    chk("t2_left", ticks_left, 3);
    ack_at = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 5) chk("t2_left_after_done1", ticks_left, 2);
      if (ack === 1'b1 && ack_at < 0) begin
        ack_at = k;
        chk("t2_busy_in_ack", busy, 0);
      end
    end
    chk("t2_ack_cycle", ack_at, 15);

    // T3: zero-length request acks straight away without starting the timer
    do_reset();
    req = 1'b1; ticks = 8'd0;
    step();
    req = 1'b0;
    chk("t3_ack", ack, 1);
    chk("t3_start", timer_start, 0);
    step();
    chk("t3_ack_single", ack, 0);
    chk("t3_start_low", timer_start, 0);

    // T4: abort coincident with the second done
    do_reset();
    req = 1'b1; ticks = 8'd4;
    step();
    req = 1'b0;
    dn = 0; n_ack = 0;
    for (int k = 1; k <= 30; k++) begin
      will_done = timer_start && (phase == 4) && !stall;
      if (will_done) dn++;
      abort = will_done && (dn == 2);
      step();
      if (abort) begin
        chk("t4_left", ticks_left, 0);
        chk("t4_busy", busy, 0);
      end
      abort = 1'b0;
      if (ack === 1'b1) n_ack++;
    end
    chk("t4_dones_seen", dn, 2);
    chk("t4_no_ack", n_ack, 0);

    // T5: second request while running is ignored
    do_reset();
    req = 1'b1; ticks = 8'd3;
    step();
    req = 1'b0;
    ack_at = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        req = 1'b1; ticks = 8'd9;
      end
      step();
      req = 1'b0;
      if (k == 4) chk("t5_left_kept", ticks_left, 3);
      if (ack === 1'b1 && ack_at < 0) ack_at = k;
    end
    chk("t5_ack_cycle", ack_at, 15);

`ifdef WAIT_SEQ_WATCHDOG_EN
    // T6: stalled timer trips the watchdog, abort clears it
    do_reset();
    stall = 1'b1;
    req = 1'b1; ticks = 8'd2;
    step();
    req = 1'b0;
    err_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (err === 1'b1 && err_at < 0) err_at = k;
    end
    chk("t6_err_cycle", err_at, 21);
    chk("t6_left_frozen", ticks_left, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_err_clear", err, 0);
    chk("t6_left_clear", ticks_left, 0);
    stall = 1'b0;
`else
    err_at = 0;
`endif

    // Randomized traffic with free-running done pulses, including done in IDLE
    stub_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom % 200) == 0;
      req        = ($urandom % 4) == 0;
      ticks      = (($urandom % 20) == 0) ? TW'($urandom_range(0, 255))
                                          : TW'($urandom_range(0, 6));
      abort      = ($urandom % 40) == 0;
      timer_done = ($urandom % 3) == 0;
      step();
    end
    reset = 1'b0; req = 1'b0; abort = 1'b0; timer_done = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
